// File: rtl/vm_command_sequencer_if.sv
// Command stream plus head-module drive signals of vm_command_sequencer.
// slave is the sequencer side, master is the command source / observer side.
interface vm_command_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [8:0] cmd_data;
    logic       costumer_mode;
    logic       owner_money_mode;
    logic       owner_supply_mode;
    logic [2:0] product;
    logic [3:0] costumer_money;
    logic [3:0] quantitiy;
    logic       busy;
    logic       err;

    modport master (
        output cmd_valid,
        output cmd_data,
        input  cmd_ready,
        input  costumer_mode,
        input  owner_money_mode,
        input  owner_supply_mode,
        input  product,
        input  costumer_money,
        input  quantitiy,
        input  busy,
        input  err
    );

    modport slave (
        input  cmd_valid,
        input  cmd_data,
        output cmd_ready,
        output costumer_mode,
        output owner_money_mode,
        output owner_supply_mode,
        output product,
        output costumer_money,
        output quantitiy,
        output busy,
        output err
    );
endinterface

// File: rtl/vm_command_sequencer.sv
// Replays queued commands as field setup, one mode strobe, then a guard gap.
// Define VM_SEQ_FIFO_EN for a DEPTH-entry command FIFO; otherwise one holding register.
module vm_command_sequencer #(
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 1,
    parameter int unsigned GAP_CYCLES    = 1,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned MAX_PRODUCT   = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    vm_command_sequencer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_e;

    localparam logic [1:0] OpBuy     = 2'b00;
    localparam logic [1:0] OpMoney   = 2'b01;
    localparam logic [1:0] OpSupply  = 2'b10;
    localparam logic [1:0] OpIllegal = 2'b11;

    localparam logic [3:0] SetupLoad  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] StrobeLoad = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] GapLoad    = 4'(GAP_CYCLES - 1);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
            SETUP_CYCLES < 1 || SETUP_CYCLES > 15 ||
            STROBE_CYCLES < 1 || STROBE_CYCLES > 15 ||
            GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : gCfgCheck
            $error("vm_command_sequencer: illegal parameter set");
        end
    endgenerate

    state_e     state_q;
    logic [3:0] cnt_q;
    logic [1:0] op_q;
    logic [2:0] product_q;
    logic [3:0] money_q;
    logic [3:0] qty_q;
    logic       costumer_mode_q;
    logic       owner_money_mode_q;
    logic       owner_supply_mode_q;
    logic       err_q;
    logic       ready_en_q;

    logic [1:0] in_op;
    logic [2:0] in_product;
    logic       cmd_fire;
    logic       cmd_legal;
    logic       push;
    logic       load;
    logic       avail;
    logic [8:0] head;

    assign in_op      = bus.cmd_data[8:7];
    assign in_product = bus.cmd_data[6:4];
    assign cmd_fire   = bus.cmd_valid && bus.cmd_ready;
    // The product field of an owner-money command is don't-care.
    assign cmd_legal  = (in_op != OpIllegal) &&
                        ((in_op == OpMoney) || (32'(in_product) <= MAX_PRODUCT));
    assign push       = cmd_fire && cmd_legal;
    assign load       = avail && ((state_q == IDLE) || (state_q == GAP && cnt_q == 4'd0));

`ifdef VM_SEQ_FIFO_EN
    localparam int unsigned AW = $clog2(DEPTH);

    logic [8:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        full;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign full          = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                           (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign avail         = (wr_ptr_q != rd_ptr_q);
    assign head          = mem_q[rd_ptr_q[AW-1:0]];
    assign bus.cmd_ready = ready_en_q && !full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (load) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.cmd_data;
    end
`else
    logic       hold_valid_q;
    logic [8:0] hold_data_q;

    assign avail         = hold_valid_q;
    assign head          = hold_data_q;
    assign bus.cmd_ready = ready_en_q && (state_q == IDLE) && !hold_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
        end else if (push) begin
            hold_valid_q <= 1'b1;
            hold_data_q  <= bus.cmd_data;
        end else if (load) begin
            hold_valid_q <= 1'b0;
        end
    end
`endif

    // Sequencer FSM: fields load on the pop edge, the strobe is a registered
    // copy of the STROBE state qualified by the loaded op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q             <= IDLE;
            cnt_q               <= '0;
            op_q                <= OpBuy;
            product_q           <= '0;
            money_q             <= '0;
            qty_q               <= '0;
            costumer_mode_q     <= 1'b0;
            owner_money_mode_q  <= 1'b0;
            owner_supply_mode_q <= 1'b0;
            err_q               <= 1'b0;
            ready_en_q          <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            err_q      <= cmd_fire && !cmd_legal;

            if (load) begin
                op_q <= head[8:7];
                case (head[8:7])
                    OpBuy: begin
                        product_q <= head[6:4];
                        money_q   <= head[3:0];
                        qty_q     <= '0;
                    end
                    OpSupply: begin
                        product_q <= head[6:4];
                        money_q   <= '0;
                        qty_q     <= head[3:0];
                    end
                    default: begin
                        product_q <= '0;
                        money_q   <= '0;
                        qty_q     <= '0;
                    end
                endcase
            end

            case (state_q)
                IDLE: begin
                    if (load) begin
                        state_q <= SETUP;
                        cnt_q   <= SetupLoad;
                    end
                end
                SETUP: begin
                    if (cnt_q == 4'd0) begin
                        state_q             <= STROBE;
                        cnt_q               <= StrobeLoad;
                        costumer_mode_q     <= (op_q == OpBuy);
                        owner_money_mode_q  <= (op_q == OpMoney);
                        owner_supply_mode_q <= (op_q == OpSupply);
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                STROBE: begin
                    if (cnt_q == 4'd0) begin
                        state_q             <= GAP;
                        cnt_q               <= GapLoad;
                        costumer_mode_q     <= 1'b0;
                        owner_money_mode_q  <= 1'b0;
                        owner_supply_mode_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                GAP: begin
                    if (cnt_q == 4'd0) begin
                        if (load) begin
                            state_q <= SETUP;
                            cnt_q   <= SetupLoad;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.costumer_mode     = costumer_mode_q;
    assign bus.owner_money_mode  = owner_money_mode_q;
    assign bus.owner_supply_mode = owner_supply_mode_q;
    assign bus.product           = product_q;
    assign bus.costumer_money    = money_q;
    assign bus.quantitiy         = qty_q;
    assign bus.err               = err_q;
    assign bus.busy              = (state_q != IDLE) || avail;

endmodule
